uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin scheduler that shares the single byte-wide UART transmitter among `N_REQ` message sources. It owns the transmitter's `tx_data`/`tx_data_en` inputs and sequences one byte at a time using the transmitter's `tx_start`/`tx_busy` feedback. It locks the grant to one requester until that requester's last byte is sent, so multi-byte messages are never interleaved on the serial line.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `TIMEOUT_CYC`, default 65535: idle-owner timeout in cycles; used only with `UART_ARB_TIMEOUT_EN`.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req` in N_REQ: requester i has a byte valid on its slice of `req_data`.
- `req_data` in 8*N_REQ: byte of requester i on bits [8i+7:8i].
- `req_last` in N_REQ: the presented byte ends requester i's message.
- `req_ack` out N_REQ: one-cycle pulse; requester i's byte was captured and the next byte may be presented.
- `grant` out N_REQ: one-hot current owner; all zero when idle.
- `tx_start` in 1: transmitter start pulse, meaning the byte was accepted.
- `tx_busy` in 1: transmitter is shifting a frame.
- `tx_data_en` out 1: request to the transmitter, level held until `tx_start`.
- `tx_data` out 8: byte to transmit, stable while `tx_data_en` is 1.
- `arb_busy` out 1: a grant is held (the FSM is not in IDLE).
- `timeout_err` out 1: one-cycle pulse when a grant is revoked by timeout; tied 0 without the macro.

## Operation
- FSM states: IDLE, LOAD, WAIT_BUSY, HOLD.
- **IDLE.** If any `req` is set and `tx_busy`=0:
  - Pick the winner by round-robin, searching from `ptr` upward with wrap-around.
  - Register `grant`, capture the winner's byte and last flag into the holding register, pulse `req_ack[winner]`.
  - Go to LOAD.
- **LOAD.** Drive `tx_data_en`=1 and `tx_data` from the holding register. On `tx_start`=1, drop `tx_data_en` the next cycle and go to WAIT_BUSY.
- **WAIT_BUSY.** Stay while `tx_busy`=1. When `tx_busy`=0:
  - If the held last flag is 1: clear `grant`, set `ptr` = owner+1 (mod N_REQ), go to IDLE.
  - Else if `req[owner]`=1: capture the next byte, pulse `req_ack[owner]`, go to LOAD.
  - Else go to HOLD.
- **HOLD.** Wait for `req[owner]`. When it arrives, capture the byte, pulse `req_ack`, go to LOAD.
- **Lock.** Other requesters' `req` is ignored while a grant is held. `req` deasserting on the owner does not release the grant.
- **`req_ack`.** Exactly one bit high, for exactly one cycle per captured byte. Only the owner is ever acked.
- **`ptr`.** Width clog2(N_REQ); reset value 0. It advances only on message completion or timeout.

## Timing
- Reset values: `tx_data_en`=0, `tx_data`=8'h00, `req_ack`=0, `grant`=0, `arb_busy`=0, `timeout_err`=0, `ptr`=0, FSM in IDLE.
- Asserting `rst_n` mid-frame clears all state immediately. Requesters must treat any message in flight as lost.
- `req` to `req_ack`/`grant`: 1 cycle (registered) when IDLE and `tx_busy`=0.
- `tx_data_en` rises the cycle after capture.
- The transmitter's edge detector makes `tx_start` arrive 1–2 cycles later. The design must not rely on the exact value.
- `tx_data_en` is low for at least 1 cycle between bytes. This is guaranteed by WAIT_BUSY, since `tx_busy` is high for a full frame.
- Byte-to-byte gap with the owner's `req` held continuously:
  - `tx_busy` falls → capture next byte (1 cycle) → `tx_data_en` high (1 cycle) → `tx_start`.
  - No other idle cycles are inserted.
- `tx_start` with `tx_data_en`=0: ignored.
- `tx_busy`=1 in IDLE (e.g. after reset mid-frame): arbitration is deferred until it falls.
- Simultaneous requests: the first set bit at or after `ptr` wins. A single requester re-requesting wins again when it is the only one requesting.

## Configuration
- Macro: `UART_ARB_TIMEOUT_EN`.
- **Defined:**
  - A counter of width clog2(TIMEOUT_CYC+1) counts cycles spent in HOLD and clears on leaving HOLD.
  - When it reaches `TIMEOUT_CYC`: clear `grant`, advance `ptr` past the owner, pulse `timeout_err` for 1 cycle, go to IDLE.
  - A byte already handed to the transmitter is never aborted.
- **Undefined:** no counter; HOLD waits indefinitely; `timeout_err` is constant 0.

## Test plan
- **Single requester.** Requester 0 sends 3 bytes 8'hA5, 8'h3C, 8'hFF with last on the third.
  - Expect 3 `req_ack[0]` pulses and 3 `tx_start` pulses, with matching `tx_data` at each `tx_start`.
  - After the final `tx_busy` fall: `grant`=0, `ptr`=1.
- **Fairness.** All 4 requesters request single-byte messages continuously from reset. Grant order must be 0,1,2,3,0.
- **Lock.** Requester 1 owns and is in HOLD; requester 2 asserts `req`. `grant` must stay 4'b0010, with no ack to requester 2, until requester 1 sends its last byte.
- **Reset during LOAD.** Pull `rst_n` low with `tx_data_en`=1. All outputs reach their reset values without a clock edge; the next arbitration starts from `ptr`=0.
- **Timeout, macro defined, `TIMEOUT_CYC`=16.** Owner stalls after a non-last byte. After 16 HOLD cycles: one `timeout_err` pulse, `grant`=0, and a pending requester 3 is granted next.
- **Timeout, macro undefined.** Same stall for 1000 cycles: `grant` is held and `timeout_err` stays 0.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester and transmitter handshake bundle for uart_tx_arbiter
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ-1:0]   req_ack;
  logic [N_REQ-1:0]   grant;
  logic               tx_start;
  logic               tx_busy;
  logic               tx_data_en;
  logic [7:0]         tx_data;
  modport master (
    output req, req_data, req_last, tx_start, tx_busy,
    input  req_ack, grant, tx_data_en, tx_data
  );
  modport slave (
    input  req, req_data, req_last, tx_start, tx_busy,
    output req_ack, grant, tx_data_en, tx_data
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin owner of a shared byte UART transmitter, grant locked per message.
// Define UART_ARB_TIMEOUT_EN to revoke a grant whose owner stalls in HOLD for TIMEOUT_CYC cycles.
module uart_tx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_tx_arbiter_if.slave bus,
  output logic             arb_busy,
  output logic             timeout_err
);
  localparam int PW = $clog2(N_REQ);
  localparam logic [PW:0] NR = (PW+1)'(N_REQ);
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);
  typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, HOLD} state_e;
  state_e state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d, owner_q, owner_d, winner, sel, owner_nxt;
  logic [PW:0] idx;
  logic [N_REQ-1:0] grant_q, grant_d, ack_q, ack_d;
  logic [7:0] data_q, data_d;
  logic last_q, last_d, found, cap, expired;
  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 1) begin : g_cfg_err
    $error("uart_tx_arbiter: N_REQ must be 2..8 and TIMEOUT_CYC at least 1");
  end
  // first requester at or after ptr, wrapping
  always_comb begin
    found  = 1'b0;
    winner = ptr_q;
    idx    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = {1'b0, ptr_q} + (PW+1)'(k);
      idx = idx >= NR ? idx - NR : idx;
      if (!found && bus.req[idx[PW-1:0]]) begin
        found  = 1'b1;
        winner = idx[PW-1:0];
      end
    end
  end
  assign owner_nxt = owner_q == PW'(N_REQ - 1) ? '0 : owner_q + 1'b1;
  assign sel       = state_q == IDLE ? winner : owner_q;
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    grant_d = grant_q;
    cap     = 1'b0;
    case (state_q)
      IDLE: if (found && !bus.tx_busy) begin
        cap     = 1'b1;
        owner_d = winner;
        grant_d = ONE << winner;
        state_d = LOAD;
      end
      LOAD: state_d = bus.tx_start ? WAIT_BUSY : LOAD;
      WAIT_BUSY: if (!bus.tx_busy) begin
        if (last_q) begin
          grant_d = '0;
          ptr_d   = owner_nxt;
          state_d = IDLE;
        end else begin
          cap     = bus.req[owner_q];
          state_d = bus.req[owner_q] ? LOAD : HOLD;
        end
      end
      HOLD: if (bus.req[owner_q]) begin
        cap     = 1'b1;
        state_d = LOAD;
      end else if (expired) begin
        grant_d = '0;
        ptr_d   = owner_nxt;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign data_d = cap ? bus.req_data[8*sel +: 8] : data_q;
  assign last_d = cap ? bus.req_last[sel] : last_q;
  assign ack_d  = cap ? ONE << sel : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      data_q  <= 8'h00;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end
  assign bus.req_ack    = ack_q;
  assign bus.grant      = grant_q;
  assign bus.tx_data_en = state_q == LOAD;
  assign bus.tx_data    = data_q;
  assign arb_busy       = state_q != IDLE;
`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_q, err_d;
  // cnt_q holds the number of HOLD cycles already spent, so HOLD lasts exactly TIMEOUT_CYC cycles
  assign expired = cnt_q == CW'(TIMEOUT_CYC - 1);
  assign cnt_d   = state_q == HOLD && state_d == HOLD ? cnt_q + 1'b1 : '0;
  assign err_d   = state_q == HOLD && state_d == IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign timeout_err = err_q;
`else
  assign expired     = 1'b0;
  assign timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench for uart_tx_arbiter with N_REQ=4, TIMEOUT_CYC=16.
// Define UART_ARB_TIMEOUT_EN at build time to exercise the stall timeout.
module tb_uart_tx_arbiter;
  localparam int FRAME = 6;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic arb_busy, timeout_err;
  int n_vec = 0;
  int n_err = 0;
  logic [8:0] rq [4][$];
  logic [7:0] tx_log [$];
  logic [3:0] grant_log [$];
  logic [3:0] grant_prev = '0;
  int ack_cnt [4] = '{default: 0};
  int bad_ack = 0;
  int busy_left = 0;
  int en_seen = 0;
  int dly = 1;
  uart_tx_arbiter_if #(.N_REQ(4)) bus ();
  uart_tx_arbiter #(.N_REQ(4), .TIMEOUT_CYC(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .arb_busy(arb_busy),
    .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic do_reset;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) rq[i].delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic wait_done(input string tag, input int n_tx);
    int c = 0;
    while (!(tx_log.size() >= n_tx && !arb_busy && !bus.tx_busy) && c < 400) begin
      @(negedge clk);
      c++;
    end
    check(tag, c < 400, 1);
  endtask
  // transmitter: tx_start 1 or 2 cycles after tx_data_en, busy for FRAME cycles
  initial begin
    bus.tx_start = 1'b0;
    bus.tx_busy  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.tx_start = 1'b0;
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) bus.tx_busy = 1'b0;
      end else if (bus.tx_data_en) begin
        en_seen++;
        if (en_seen >= dly) begin
          bus.tx_start = 1'b1;
          bus.tx_busy  = 1'b1;
          busy_left    = FRAME;
          tx_log.push_back(bus.tx_data);
          en_seen      = 0;
          dly          = 3 - dly;
        end
      end else en_seen = 0;
    end
  end
  // requesters present the head of their queue and pop it on req_ack
  initial begin
    logic [8:0] head;
    bus.req      = '0;
    bus.req_data = '0;
    bus.req_last = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (bus.req_ack[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        head = rq[i].size() > 0 ? rq[i][0] : 9'h000;
        bus.req[i] = rq[i].size() > 0;
        bus.req_data[8*i +: 8] = head[7:0];
        bus.req_last[i] = head[8];
      end
    end
  end
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) if (bus.req_ack[i]) ack_cnt[i]++;
    if ($countones(bus.req_ack) > 1 || (bus.req_ack & ~bus.grant) != 4'b0) bad_ack++;
    if (bus.grant != 4'b0 && bus.grant != grant_prev) grant_log.push_back(bus.grant);
    grant_prev = bus.grant;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish within 200000");
    $fatal(1, "watchdog expired");
  end
  initial begin
    int base, gbase, cnt, a2;
    logic bad;
`ifdef UART_ARB_TIMEOUT_EN
    int hits;
`endif
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("rst_tx_data_en", bus.tx_data_en, 0);
    check("rst_tx_data", bus.tx_data, 8'h00);
    check("rst_req_ack", bus.req_ack, 0);
    check("rst_grant", bus.grant, 0);
    check("rst_arb_busy", arb_busy, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_ptr", dut.ptr_q, 0);
    rst_n = 1'b1;
    @(negedge clk);
    // single requester, three bytes
    rq[0].push_back({1'b0, 8'hA5});
    rq[0].push_back({1'b0, 8'h3C});
    rq[0].push_back({1'b1, 8'hFF});
    @(negedge clk);
    check("t1_grant_before", bus.grant, 0);
    @(negedge clk);
    check("t1_grant", bus.grant, 4'b0001);
    check("t1_ack", bus.req_ack, 4'b0001);
    check("t1_en", bus.tx_data_en, 1);
    check("t1_data0", bus.tx_data, 8'hA5);
    check("t1_arb_busy", arb_busy, 1);
    @(negedge clk);
    check("t1_ack_pulse", bus.req_ack, 0);
    cnt = 0;
    while (bus.tx_busy !== 1'b1 && cnt < 20) begin @(negedge clk); cnt++; end
    while (bus.tx_busy === 1'b1 && cnt < 40) begin @(negedge clk); cnt++; end
    check("t1_frame", cnt < 40, 1);
    @(negedge clk);
    check("t1_gap_en", bus.tx_data_en, 1);
    check("t1_gap_ack", bus.req_ack, 4'b0001);
    check("t1_gap_data", bus.tx_data, 8'h3C);
    wait_done("t1_done", 3);
    repeat (2) @(negedge clk);
    check("t1_acks", ack_cnt[0], 3);
    check("t1_starts", tx_log.size(), 3);
    check("t1_byte0", tx_log[0], 8'hA5);
    check("t1_byte1", tx_log[1], 8'h3C);
    check("t1_byte2", tx_log[2], 8'hFF);
    check("t1_grant_end", bus.grant, 0);
    check("t1_ptr_end", dut.ptr_q, 1);
    // fairness, all four requesting from reset
    do_reset();
    base  = tx_log.size();
    gbase = grant_log.size();
    for (int i = 0; i < 4; i++) begin
      rq[i].push_back({1'b1, 8'(16 + i)});
      rq[i].push_back({1'b1, 8'(32 + i)});
    end
    wait_done("t2_done", base + 8);
    repeat (2) @(negedge clk);
    check("t2_g0", grant_log[gbase], 4'b0001);
    check("t2_g1", grant_log[gbase+1], 4'b0010);
    check("t2_g2", grant_log[gbase+2], 4'b0100);
    check("t2_g3", grant_log[gbase+3], 4'b1000);
    check("t2_g4", grant_log[gbase+4], 4'b0001);
    check("t2_b0", tx_log[base], 8'h10);
    check("t2_b3", tx_log[base+3], 8'h13);
    check("t2_b4", tx_log[base+4], 8'h20);
    check("t2_ptr", dut.ptr_q, 0);
    // lock: requester 1 stalls mid-message while requester 2 waits
    base  = tx_log.size();
    gbase = grant_log.size();
    rq[1].push_back({1'b0, 8'h11});
    cnt = 0;
    while (!(tx_log.size() > base && bus.tx_busy === 1'b0) && cnt < 100) begin @(negedge clk); cnt++; end
    check("t3_reach_hold", cnt < 100, 1);
    rq[2].push_back({1'b1, 8'h22});
    a2  = ack_cnt[2];
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus.grant !== 4'b0010 || bus.req_ack[2] !== 1'b0) bad = 1'b1;
    end
    check("t3_lock", bad, 0);
    check("t3_no_ack2", ack_cnt[2], a2);
    check("t3_arb_busy", arb_busy, 1);
    rq[1].push_back({1'b1, 8'h12});
    wait_done("t3_done", base + 3);
    repeat (2) @(negedge clk);
    check("t3_b0", tx_log[base], 8'h11);
    check("t3_b1", tx_log[base+1], 8'h12);
    check("t3_b2", tx_log[base+2], 8'h22);
    check("t3_g0", grant_log[gbase], 4'b0010);
    check("t3_g1", grant_log[gbase+1], 4'b0100);
    check("t3_ptr", dut.ptr_q, 3);
    // reset while the byte is offered to the transmitter
    rq[0].push_back({1'b1, 8'h44});
    cnt = 0;
    while (bus.tx_data_en !== 1'b1 && cnt < 50) begin @(negedge clk); cnt++; end
    check("t4_reach_load", cnt < 50, 1);
    rst_n = 1'b0;
    #1;
    check("t4_en", bus.tx_data_en, 0);
    check("t4_data", bus.tx_data, 8'h00);
    check("t4_grant", bus.grant, 0);
    check("t4_ack", bus.req_ack, 0);
    check("t4_arb_busy", arb_busy, 0);
    check("t4_err", timeout_err, 0);
    check("t4_ptr", dut.ptr_q, 0);
    rq[0].delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base  = tx_log.size();
    gbase = grant_log.size();
    rq[1].push_back({1'b1, 8'h55});
    rq[3].push_back({1'b1, 8'h77});
    wait_done("t4_done", base + 2);
    repeat (2) @(negedge clk);
    check("t4_g0", grant_log[gbase], 4'b0010);
    check("t4_g1", grant_log[gbase+1], 4'b1000);
    check("t4_b0", tx_log[base], 8'h55);
    check("t4_b1", tx_log[base+1], 8'h77);
    // owner stalls after a non-last byte, requester 3 pending
    base  = tx_log.size();
    gbase = grant_log.size();
    rq[0].push_back({1'b0, 8'h66});
    rq[3].push_back({1'b1, 8'h88});
    cnt = 0;
    while (!(tx_log.size() > base && bus.tx_busy === 1'b0) && cnt < 100) begin @(negedge clk); cnt++; end
    check("t5_reach_hold", cnt < 100, 1);
`ifdef UART_ARB_TIMEOUT_EN
    cnt  = 0;
    hits = 0;
    while (timeout_err !== 1'b1 && cnt < 100) begin
      if (bus.grant != 4'b0 && !bus.tx_busy && !bus.tx_data_en) hits++;
      @(negedge clk);
      cnt++;
    end
    check("t5_err_seen", cnt < 100, 1);
    check("t5_stall_cycles", hits, 17);
    check("t5_grant_cleared", bus.grant, 0);
    check("t5_ptr", dut.ptr_q, 1);
    @(negedge clk);
    check("t5_err_pulse", timeout_err, 0);
    wait_done("t5_done", base + 2);
    repeat (2) @(negedge clk);
    check("t5_g0", grant_log[gbase], 4'b0001);
    check("t5_g1", grant_log[gbase+1], 4'b1000);
    check("t5_b1", tx_log[base+1], 8'h88);
`else
    bad = 1'b0;
    repeat (1000) begin
      @(negedge clk);
      if (bus.grant !== 4'b0001 || timeout_err !== 1'b0) bad = 1'b1;
    end
    check("t5_hold_forever", bad, 0);
    check("t5_grant_held", bus.grant, 4'b0001);
    rq[0].push_back({1'b1, 8'h67});
    wait_done("t5_done", base + 3);
    repeat (2) @(negedge clk);
    check("t5_g0", grant_log[gbase], 4'b0001);
    check("t5_g1", grant_log[gbase+1], 4'b1000);
    check("t5_b1", tx_log[base+1], 8'h67);
    check("t5_b2", tx_log[base+2], 8'h88);
`endif
    check("ack_onehot_owner", bad_ack, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
